// File: rtl/tb_cmd_scheduler.sv
// tb_cmd_scheduler: sequences decoded scenario commands onto testbench action
// modules (wait / set-inject / check blocks).
//
// Accepts one command at a time over a valid/ready handshake. It drives a
// one-hot select plus a one-cycle args-valid pulse to the addressed module.
// For blocking commands it then waits for that module's done pulse, guarded
// by a watchdog. It reports end-of-test, error status and a saturating count
// of completed commands.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   i_cmd_valid        command available from the scenario reader
//   o_cmd_ready        scheduler idle and able to accept a command
//   i_cmd_target       index of the addressed action module
//   i_cmd_blocking     1: wait for done, 0: fire and continue
//   i_cmd_last         final command of the scenario
//   o_sel              one-hot select to the action modules
//   o_args_valid       one-cycle pulse, shared args bus valid
//   i_done             per-module completion pulses
//   o_busy             command in flight (ISSUE, WAIT_DONE or GAP)
//   o_end_of_test      sticky, scenario finished or aborted
//   o_error            sticky, scenario aborted on error
//   o_err_code         0 none, 1 bad target, 2 watchdog timeout
//   o_cmd_count        completed commands, saturating
//
// Optional feature: define TB_CMD_SCHED_TRACE_EN to print a trace of issues,
// completions, timeouts and the final summary. Cycle behaviour is unchanged.

module tb_cmd_scheduler #(
  parameter int unsigned NB_TARGETS  = 4,
  parameter int unsigned TGT_W       = 2,
  parameter int unsigned WDOG_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [TGT_W-1:0]      i_cmd_target,
  input  logic                  i_cmd_blocking,
  input  logic                  i_cmd_last,
  output logic [NB_TARGETS-1:0] o_sel,
  output logic                  o_args_valid,
  input  logic [NB_TARGETS-1:0] i_done,
  output logic                  o_busy,
  output logic                  o_end_of_test,
  output logic                  o_error,
  output logic [1:0]            o_err_code,
  output logic [15:0]           o_cmd_count
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WDOG_W = 32;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_TGT = 2'd1;
  localparam logic [1:0] ERR_WDOG    = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_GAP       = 3'd3,
    S_END       = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Latched command fields
  logic [TGT_W-1:0]  tgt_q, tgt_d;
  logic              blk_q, last_q;
  logic [WDOG_W-1:0] wdog_q;

  // Next values of the registered outputs
  logic                  ready_d;
  logic [NB_TARGETS-1:0] sel_d;
  logic                  args_valid_d;
  logic                  busy_d;
  logic                  eot_d;
  logic                  error_d;
  logic [1:0]            err_code_d;
  logic [CNT_W-1:0]      count_d;

  logic                  accept;
  logic                  bad_tgt;
  logic                  done_hit;
  logic                  wdog_exp;
  logic [NB_TARGETS-1:0] tgt_mask_q;

  assign accept     = (state_q == S_IDLE) && i_cmd_valid;
  assign bad_tgt    = (32'(i_cmd_target) >= NB_TARGETS);
  assign tgt_mask_q = NB_TARGETS'(1) << tgt_q;
  // Only the addressed module's done counts; other bits are ignored
  assign done_hit   = |(i_done & tgt_mask_q);
  assign wdog_exp   = (wdog_q == WDOG_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (i_cmd_valid) state_d = bad_tgt ? S_ERROR : S_ISSUE;
      S_ISSUE:     state_d = blk_q ? S_WAIT_DONE : S_GAP;
      // done beats a simultaneous watchdog expiry
      S_WAIT_DONE: begin
        if (done_hit)      state_d = S_GAP;
        else if (wdog_exp) state_d = S_ERROR;
      end
      S_GAP:       state_d = last_q ? S_END : S_IDLE;
      S_END:       state_d = S_END;
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output logic: next-cycle output values decoded from the next state
  always_comb begin
    tgt_d        = accept ? i_cmd_target : tgt_q;
    ready_d      = (state_d == S_IDLE);
    sel_d        = '0;
    args_valid_d = (state_d == S_ISSUE);
    busy_d       = (state_d == S_ISSUE) || (state_d == S_WAIT_DONE) ||
                   (state_d == S_GAP);
    eot_d        = (state_d == S_END) || (state_d == S_ERROR);
    error_d      = (state_d == S_ERROR);
    err_code_d   = o_err_code;
    count_d      = o_cmd_count;

    if ((state_d == S_ISSUE) || (state_d == S_WAIT_DONE))
      sel_d = NB_TARGETS'(1) << tgt_d;

    if (accept && bad_tgt)
      err_code_d = ERR_BAD_TGT;
    else if ((state_q == S_WAIT_DONE) && !done_hit && wdog_exp)
      err_code_d = ERR_WDOG;

    // GAP is always entered fresh and lasts one cycle
    if ((state_d == S_GAP) && (o_cmd_count != CNT_MAX))
      count_d = o_cmd_count + CNT_W'(1);
  end

  // Latches, watchdog and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt_q         <= '0;
      blk_q         <= 1'b0;
      last_q        <= 1'b0;
      wdog_q        <= '0;
      o_cmd_ready   <= 1'b1;
      o_sel         <= '0;
      o_args_valid  <= 1'b0;
      o_busy        <= 1'b0;
      o_end_of_test <= 1'b0;
      o_error       <= 1'b0;
      o_err_code    <= ERR_NONE;
      o_cmd_count   <= '0;
    end else begin
      tgt_q <= tgt_d;
      if (accept) begin
        blk_q  <= i_cmd_blocking;
        last_q <= i_cmd_last;
      end
      // Counts WAIT_DONE cycles from 0; zero in every other state
      if (state_q == S_WAIT_DONE) wdog_q <= wdog_q + WDOG_W'(1);
      else                        wdog_q <= '0;
      o_cmd_ready   <= ready_d;
      o_sel         <= sel_d;
      o_args_valid  <= args_valid_d;
      o_busy        <= busy_d;
      o_end_of_test <= eot_d;
      o_error       <= error_d;
      o_err_code    <= err_code_d;
      o_cmd_count   <= count_d;
    end
  end

`ifdef TB_CMD_SCHED_TRACE_EN
  // Simulation trace of scheduler events
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == S_ISSUE)
        $display("%0t cmd_sched: issue target=%0d blocking=%0b count=%0d",
                 $time, tgt_q, blk_q, o_cmd_count);
      if ((state_q == S_WAIT_DONE) && done_hit)
        $display("%0t cmd_sched: done target=%0d after %0d wait cycles",
                 $time, tgt_q, wdog_q + WDOG_W'(1));
      else if ((state_q == S_WAIT_DONE) && wdog_exp)
        $display("%0t cmd_sched: watchdog target=%0d after %0d wait cycles",
                 $time, tgt_q, wdog_q + WDOG_W'(1));
      if ((state_d == S_END) && (state_q != S_END))
        $display("%0t cmd_sched: end of test count=%0d err_code=%0d",
                 $time, count_d, err_code_d);
      if ((state_d == S_ERROR) && (state_q != S_ERROR))
        $display("%0t cmd_sched: abort count=%0d err_code=%0d",
                 $time, count_d, err_code_d);
    end
  end
`endif

endmodule

// File: tb/tb_tb_cmd_scheduler.sv
// Self-checking bench for tb_cmd_scheduler. Scenarios of commands are driven
// one at a time. The expected bus behaviour of each command is derived from
// its target, blocking flag and the cycle at which done is returned.
module tb_tb_cmd_scheduler;

  localparam int unsigned NB_TARGETS  = 4;
  localparam int unsigned TGT_W       = 3;
  localparam int unsigned WDOG_CYCLES = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic [TGT_W-1:0]      i_cmd_target;
  logic                  i_cmd_blocking;
  logic                  i_cmd_last;
  logic [NB_TARGETS-1:0] o_sel;
  logic                  o_args_valid;
  logic [NB_TARGETS-1:0] i_done;
  logic                  o_busy;
  logic                  o_end_of_test;
  logic                  o_error;
  logic [1:0]            o_err_code;
  logic [15:0]           o_cmd_count;

  always #5 clk = ~clk;

  tb_cmd_scheduler #(
    .NB_TARGETS (NB_TARGETS),
    .TGT_W      (TGT_W),
    .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_target  (i_cmd_target),
    .i_cmd_blocking(i_cmd_blocking),
    .i_cmd_last    (i_cmd_last),
    .o_sel         (o_sel),
    .o_args_valid  (o_args_valid),
    .i_done        (i_done),
    .o_busy        (o_busy),
    .o_end_of_test (o_end_of_test),
    .o_error       (o_error),
    .o_err_code    (o_err_code),
    .o_cmd_count   (o_cmd_count)
  );

  // done_at: WAIT_DONE cycle index (0-based) carrying the target's done;
  // any value >= WDOG_CYCLES means done never arrives
  typedef struct {
    int tgt;
    bit blk;
    bit last;
    int done_at;
  } cmd_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned exp_count;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_target = '0;
    i_cmd_blocking = 1'b0;
    i_cmd_last  = 1'b0;
    i_done      = '0;
    step();
    step();
    check("rst_ready", 32'(o_cmd_ready),   32'd1);
    check("rst_sel",   32'(o_sel),         32'd0);
    check("rst_args",  32'(o_args_valid),  32'd0);
    check("rst_busy",  32'(o_busy),        32'd0);
    check("rst_eot",   32'(o_end_of_test), 32'd0);
    check("rst_err",   32'(o_error),       32'd0);
    check("rst_code",  32'(o_err_code),    32'd0);
    check("rst_count", 32'(o_cmd_count),   32'd0);
    rst_n     = 1'b1;
    exp_count = 0;
  endtask

  // Runs one command from an IDLE cycle. end_code: -1 still running,
  // 0 clean end of test, 1 bad target, 2 watchdog
  task automatic do_cmd(input cmd_t c, output int end_code);
    int unsigned onehot;
    bit timeout;
    end_code = -1;
    check("idle_ready", 32'(o_cmd_ready), 32'd1);
    check("idle_busy",  32'(o_busy),      32'd0);
    check("idle_sel",   32'(o_sel),       32'd0);
    check("idle_count", 32'(o_cmd_count), exp_count);
    i_cmd_valid    = 1'b1;
    i_cmd_target   = TGT_W'(c.tgt);
    i_cmd_blocking = c.blk;
    i_cmd_last     = c.last;
    step();
    // Fields after the handshake must not matter
    i_cmd_valid    = 1'b0;
    i_cmd_target   = TGT_W'($urandom);
    i_cmd_blocking = 1'($urandom);
    i_cmd_last     = 1'($urandom);

    if (c.tgt >= int'(NB_TARGETS)) begin
      check("bad_code",  32'(o_err_code),    32'd1);
      check("bad_err",   32'(o_error),       32'd1);
      check("bad_eot",   32'(o_end_of_test), 32'd1);
      check("bad_sel",   32'(o_sel),         32'd0);
      check("bad_args",  32'(o_args_valid),  32'd0);
      check("bad_busy",  32'(o_busy),        32'd0);
      check("bad_count", 32'(o_cmd_count),   exp_count);
      end_code = 1;
      return;
    end

    onehot = 32'd1 << c.tgt;
    check("issue_sel",   32'(o_sel),        onehot);
    check("issue_args",  32'(o_args_valid), 32'd1);
    check("issue_busy",  32'(o_busy),       32'd1);
    check("issue_ready", 32'(o_cmd_ready),  32'd0);
    // done during ISSUE, even the target's own, must be ignored
    i_done = NB_TARGETS'($urandom);

    timeout = 1'b0;
    if (c.blk) begin
      for (int k = 0; k < int'(WDOG_CYCLES); k++) begin
        step();
        check("wait_sel",  32'(o_sel),        onehot);
        check("wait_args", 32'(o_args_valid), 32'd0);
        check("wait_busy", 32'(o_busy),       32'd1);
        i_done = NB_TARGETS'($urandom) & ~NB_TARGETS'(onehot);
        if (k == c.done_at) begin
          i_done = i_done | NB_TARGETS'(onehot);
          break;
        end
      end
      timeout = (c.done_at >= int'(WDOG_CYCLES));
    end

    step();
    i_done = '0;
    if (timeout) begin
      check("wdog_code",  32'(o_err_code),    32'd2);
      check("wdog_err",   32'(o_error),       32'd1);
      check("wdog_eot",   32'(o_end_of_test), 32'd1);
      check("wdog_sel",   32'(o_sel),         32'd0);
      check("wdog_busy",  32'(o_busy),        32'd0);
      check("wdog_count", 32'(o_cmd_count),   exp_count);
      end_code = 2;
      return;
    end

    check("gap_sel",   32'(o_sel),         32'd0);
    check("gap_args",  32'(o_args_valid),  32'd0);
    check("gap_busy",  32'(o_busy),        32'd1);
    check("gap_ready", 32'(o_cmd_ready),   32'd0);
    check("gap_eot",   32'(o_end_of_test), 32'd0);
    if (exp_count != 32'hFFFF) exp_count++;
    step();

    if (c.last) begin
      check("end_eot",   32'(o_end_of_test), 32'd1);
      check("end_err",   32'(o_error),       32'd0);
      check("end_code",  32'(o_err_code),    32'd0);
      check("end_busy",  32'(o_busy),        32'd0);
      check("end_ready", 32'(o_cmd_ready),   32'd0);
      check("end_count", 32'(o_cmd_count),   exp_count);
      end_code = 0;
    end
  endtask

  // Terminal states hold and ignore new commands and done pulses
  task automatic check_sticky(input int code);
    repeat (3) begin
      i_cmd_valid  = 1'b1;
      i_cmd_target = TGT_W'($urandom);
      i_done       = NB_TARGETS'($urandom);
      step();
      check("hold_eot",   32'(o_end_of_test), 32'd1);
      check("hold_err",   32'(o_error),       32'(code != 0));
      check("hold_code",  32'(o_err_code),    32'(code));
      check("hold_ready", 32'(o_cmd_ready),   32'd0);
      check("hold_sel",   32'(o_sel),         32'd0);
      check("hold_args",  32'(o_args_valid),  32'd0);
      check("hold_busy",  32'(o_busy),        32'd0);
      check("hold_count", 32'(o_cmd_count),   exp_count);
    end
    i_cmd_valid = 1'b0;
    i_done      = '0;
  endtask

  task automatic run_scenario(input cmd_t cmds[$]);
    int code;
    do_reset();
    code = -1;
    foreach (cmds[i]) begin
      do_cmd(cmds[i], code);
      if (code >= 0) break;
    end
    if (code >= 0) check_sticky(code);
  endtask

  initial begin
    cmd_t q[$];
    cmd_t c;
    int code;
    int n;

    // Non-blocking, blocking with done, end
    q = '{'{tgt:1, blk:1'b0, last:1'b0, done_at:0},
          '{tgt:2, blk:1'b1, last:1'b0, done_at:9},
          '{tgt:0, blk:1'b0, last:1'b1, done_at:0}};
    run_scenario(q);
    // Watchdog timeout
    q = '{'{tgt:0, blk:1'b1, last:1'b0, done_at:1000}};
    run_scenario(q);
    // Out-of-range target
    q = '{'{tgt:5, blk:1'b0, last:1'b0, done_at:0}};
    run_scenario(q);
    // Done in the expiry cycle wins, then a last command
    q = '{'{tgt:3, blk:1'b1, last:1'b0, done_at:int'(WDOG_CYCLES) - 1},
          '{tgt:1, blk:1'b0, last:1'b1, done_at:0}};
    run_scenario(q);

    // Reset while waiting for done
    do_reset();
    c = '{tgt:1, blk:1'b0, last:1'b0, done_at:0};
    do_cmd(c, code);
    i_cmd_valid    = 1'b1;
    i_cmd_target   = TGT_W'(2);
    i_cmd_blocking = 1'b1;
    i_cmd_last     = 1'b0;
    step();
    i_cmd_valid = 1'b0;
    repeat (4) step();
    check("mid_sel", 32'(o_sel), 32'h4);
    rst_n = 1'b0;
    step();
    check("mrst_sel",   32'(o_sel),        32'd0);
    check("mrst_busy",  32'(o_busy),       32'd0);
    check("mrst_args",  32'(o_args_valid), 32'd0);
    check("mrst_ready", 32'(o_cmd_ready),  32'd1);
    check("mrst_count", 32'(o_cmd_count),  32'd0);
    rst_n     = 1'b1;
    exp_count = 0;
    c = '{tgt:2, blk:1'b1, last:1'b1, done_at:3};
    do_cmd(c, code);
    check("mrst_end", 32'(code), 32'd0);

    // Randomized scenarios
    for (int s = 0; s < 12; s++) begin
      q = {};
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        c.tgt     = ($urandom_range(0, 11) == 0) ? int'($urandom_range(4, 7))
                                                 : int'($urandom_range(0, 3));
        c.blk     = 1'($urandom);
        c.last    = (i == n - 1);
        c.done_at = int'($urandom_range(0, 18));
        q.push_back(c);
      end
      run_scenario(q);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
